// File: rtl/shader_core.sv
// shader_core: per-pixel execution unit of the tiny shader.
// Executes NUM_INSTR instructions from the rotating store head, one per cycle,
// and delivers a registered RGB222 colour at the end of each pixel.
module shader_core #(
  parameter int unsigned NUM_INSTR = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [5:0] x_i,
  input  logic [5:0] y_i,
  input  logic [7:0] instr_i,
  output logic       shift_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [5:0] rgb_o
);

  localparam int unsigned DW = 6;
  localparam int unsigned CW = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_INSTR - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          accept;
  logic          last;
  logic [CW-1:0] count;
  logic [DW-1:0] regs      [4];
  logic [DW-1:0] regs_next [4];
  logic [DW-1:0] color;
  logic [DW-1:0] color_next;
  logic [DW-1:0] x_lat;
  logic [DW-1:0] y_lat;
  logic [1:0]    dst;
  logic [1:0]    src;
  logic [DW-1:0] rd;
  logic [DW-1:0] rs;

  // Store rotation and busy follow the state, but drop in the reset cycle itself
  // so an aborted pixel issues no shift while the store is being realigned.
  assign shift_o = (state == RUN) && !rst_i;
  assign busy_o  = (state == RUN) && !rst_i;

  assign dst = instr_i[1:0];
  assign src = instr_i[3:2];
  assign rd  = regs[dst];
  assign rs  = regs[src];

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept in IDLE, leave RUN after the last instruction.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        last = (count == LAST);
        if (last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Instruction decode and execute for the current head word.
  always_comb begin
    regs_next  = regs;
    color_next = color;
    if (state == RUN) begin
      case (instr_i[7:6])
        2'b00: begin
          case (instr_i[5:2])
            4'b0000: color_next     = rd;
            4'b0100: regs_next[dst] = x_lat;
            4'b0101: regs_next[dst] = y_lat;
            default: ;
          endcase
        end
        2'b01: begin
          case (instr_i[5:4])
            2'b00:   regs_next[dst] = rd & rs;
            2'b01:   regs_next[dst] = rd | rs;
            2'b10:   regs_next[dst] = DW'(rd + rs);
            default: regs_next[dst] = rd ^ rs;
          endcase
        end
        2'b10: begin
          case (instr_i[5:4])
            2'b00:   regs_next[dst] = rs;
            2'b01:   regs_next[dst] = DW'(rd - rs);
            2'b10:   regs_next[dst] = rs >> 1;
            default: regs_next[dst] = DW'(rs << 1);
          endcase
        end
        default: regs_next[dst] = {2'b00, instr_i[5:2]};
      endcase
    end
  end

  // Datapath registers, counter, and the pixel result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
      color  <= '0;
      x_lat  <= '0;
      y_lat  <= '0;
      count  <= '0;
      rgb_o  <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= last;
      if (accept) begin
        for (int i = 0; i < 4; i++) begin
          regs[i] <= '0;
        end
        color <= '0;
        x_lat <= x_i;
        y_lat <= y_i;
        count <= '0;
      end else if (state == RUN) begin
        regs  <= regs_next;
        color <= color_next;
        count <= CW'(count + 1'b1);
        if (last) begin
          rgb_o <= color_next;
        end
      end
    end
  end

endmodule
